// File: rtl/pulse_stream_pkg.sv
// Shared types for the pulse engine / DAC sink sample stream.
//   IQ_W         : width of one {Q,I} sample on the stream
//   iq_sample_t  : packed {Q[31:16], I[15:0]}, signed Q1.15
//   sink_state_t : playout FSM states of the DAC sink
package pulse_stream_pkg;

    localparam int unsigned IQ_W = 32;

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } iq_sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        HOLD   = 2'd3
    } sink_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and level)
//   wr_en      : write request, ignored when full
//   wr_data    : write data
//   rd_en      : read (pop) request, ignored when empty
//   rd_data    : head entry, valid whenever !empty
//   level      : occupancy, 0..2**AW
//   full/empty : decoded from the level register
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push, pop;

    assign full  = (level_q == DEPTH);
    assign empty = (level_q == '0);
    // A full FIFO refuses the write even when a pop frees a slot this cycle.
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ONE : rd_ptr_q;
        // Extra pointer bit makes the difference the true occupancy, including full.
        level_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

endmodule

// File: rtl/pulse_dac_sink.sv
// AXI-Stream sink that buffers {Q,I} samples and plays them to the DAC at a fixed cadence.
//   clk, rst_n       : clock, asynchronous active-low reset
//   s_axis_*         : 32-bit {Q,I} sample stream, tready from FIFO fullness
//   dac_i/dac_q      : DAC codes, IDLE_CODE when not playing
//   dac_valid        : dac_* carry a real sample this strobe period
//   active           : FSM is in PRIME, STREAM or HOLD
//   fifo_level       : current FIFO occupancy
//   underflow_cnt    : saturating count of mid-pulse starvations
//   underflow_flag   : sticky starvation flag
//   clear_status     : strobe clearing underflow_cnt/flag (wins over a coincident increment)
module pulse_dac_sink
    import pulse_stream_pkg::*;
#(
    parameter int unsigned     FIFO_AW     = 5,
    parameter int unsigned     PRIME_LEVEL = 8,
    parameter int unsigned     RATE_DIV    = 1,
    parameter int unsigned     GAP_CYC     = 16,
    parameter logic [IQ_W-1:0] IDLE_CODE   = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IQ_W-1:0]   s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [15:0]       dac_i,
    output logic [15:0]       dac_q,
    output logic              dac_valid,
    output logic              active,
    output logic [FIFO_AW:0]  fifo_level,
    output logic [15:0]       underflow_cnt,
    output logic              underflow_flag,
    input  logic              clear_status
);

    localparam int unsigned RCW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int unsigned GCW = $clog2(GAP_CYC + 1);

    localparam logic [RCW-1:0]     RATE_LAST = RCW'(RATE_DIV - 1);
    localparam logic [GCW-1:0]     GAP_LAST  = GCW'(GAP_CYC - 1);
    localparam logic [FIFO_AW+1:0] PRIME_LVL = (FIFO_AW + 2)'(PRIME_LEVEL);

    sink_state_t      state_q, state_d;
    logic [RCW-1:0]   rate_cnt_q, rate_cnt_d;
    logic [GCW-1:0]   gap_q, gap_d;
    iq_sample_t       sample_q, sample_d;
    logic             dac_valid_q, dac_valid_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             flag_q, flag_d;

    logic             push, pop, strobe, underrun;
    logic             fifo_full, fifo_empty;
    logic [IQ_W-1:0]  fifo_rd_data;
    logic [FIFO_AW+1:0] level_after_push;

    sync_fifo #(
        .WIDTH (IQ_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (s_axis_tdata),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign s_axis_tready = !fifo_full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign strobe        = (rate_cnt_q == RATE_LAST);
    assign rate_cnt_d    = strobe ? '0 : rate_cnt_q + RCW'(1);

    // PRIME never pops, so this is the occupancy after the current edge; leaving PRIME on it
    // lets the first strobe in STREAM follow the edge that brings the level to PRIME_LEVEL.
    assign level_after_push = {1'b0, fifo_level} + {{(FIFO_AW + 1){1'b0}}, push};

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        sample_d    = sample_q;
        dac_valid_d = dac_valid_q;
        pop         = 1'b0;
        underrun    = 1'b0;
        unique case (state_q)
            IDLE: begin
                sample_d    = IDLE_CODE;
                dac_valid_d = 1'b0;
                gap_d       = '0;
                if (push) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                sample_d    = IDLE_CODE;
                dac_valid_d = 1'b0;
                if (level_after_push >= PRIME_LVL) begin
                    state_d = STREAM;
                    gap_d   = '0;
                end else if (push) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    // Short pulse: source went quiet before reaching the prime level.
                    if (!fifo_empty) begin
                        state_d = STREAM;
                        gap_d   = '0;
                    end
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            STREAM: begin
                if (strobe) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        sample_d    = fifo_rd_data;
                        dac_valid_d = 1'b1;
                    end else begin
                        sample_d    = IDLE_CODE;
                        dac_valid_d = 1'b0;
                        state_d     = HOLD;
                        gap_d       = '0;
                    end
                end
            end
            HOLD: begin
                sample_d    = IDLE_CODE;
                dac_valid_d = 1'b0;
                if (push) begin
                    // Data resumed before the end-of-pulse gap: the pulse was starved.
                    underrun = 1'b1;
                    state_d  = PRIME;
                    gap_d    = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (clear_status) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (underrun) begin
            flag_d = 1'b1;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rate_cnt_q  <= '0;
            gap_q       <= '0;
            sample_q    <= IDLE_CODE;
            dac_valid_q <= 1'b0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_cnt_q  <= rate_cnt_d;
            gap_q       <= gap_d;
            sample_q    <= sample_d;
            dac_valid_q <= dac_valid_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
        end
    end

    assign dac_i          = sample_q.i;
    assign dac_q          = sample_q.q;
    assign dac_valid      = dac_valid_q;
    assign active         = (state_q != IDLE);
    assign underflow_cnt  = cnt_q;
    assign underflow_flag = flag_q;

endmodule

// File: tb/tb_pulse_dac_sink.sv
// Bench for pulse_dac_sink: instance A runs at RATE_DIV=1, instance B at RATE_DIV=4.
// Both are checked against queues of accepted beats and a pulse-level underrun model.
module tb_pulse_dac_sink;

    localparam logic [31:0] IDLE_CODE = 32'h0;
    localparam int          GAP       = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_tvalid, a_tready, a_dac_valid, a_active, a_uflag, a_clear;
    logic [31:0] a_tdata;
    logic [15:0] a_dac_i, a_dac_q, a_ucnt;
    logic [5:0]  a_level;

    logic        b_rst_n, b_tvalid, b_tready, b_dac_valid, b_active, b_uflag, b_clear;
    logic [31:0] b_tdata;
    logic [15:0] b_dac_i, b_dac_q, b_ucnt;
    logic [5:0]  b_level;

    pulse_dac_sink #(
        .FIFO_AW     (5),
        .PRIME_LEVEL (8),
        .RATE_DIV    (1),
        .GAP_CYC     (GAP),
        .IDLE_CODE   (IDLE_CODE)
    ) u_dut_a (
        .clk            (clk),
        .rst_n          (a_rst_n),
        .s_axis_tdata   (a_tdata),
        .s_axis_tvalid  (a_tvalid),
        .s_axis_tready  (a_tready),
        .dac_i          (a_dac_i),
        .dac_q          (a_dac_q),
        .dac_valid      (a_dac_valid),
        .active         (a_active),
        .fifo_level     (a_level),
        .underflow_cnt  (a_ucnt),
        .underflow_flag (a_uflag),
        .clear_status   (a_clear)
    );

    pulse_dac_sink #(
        .FIFO_AW     (5),
        .PRIME_LEVEL (8),
        .RATE_DIV    (4),
        .GAP_CYC     (GAP),
        .IDLE_CODE   (IDLE_CODE)
    ) u_dut_b (
        .clk            (clk),
        .rst_n          (b_rst_n),
        .s_axis_tdata   (b_tdata),
        .s_axis_tvalid  (b_tvalid),
        .s_axis_tready  (b_tready),
        .dac_i          (b_dac_i),
        .dac_q          (b_dac_q),
        .dac_valid      (b_dac_valid),
        .active         (b_active),
        .fifo_level     (b_level),
        .underflow_cnt  (b_ucnt),
        .underflow_flag (b_uflag),
        .clear_status   (b_clear)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int unsigned seq     = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          played_a = 0;
    int          played_b = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] next_data();
        seq++;
        return {16'(seq), 16'($urandom())};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A plays one new sample per valid cycle; otherwise the idle code must show.
    always @(negedge clk) begin
        if (a_rst_n) begin
            if (a_dac_valid) begin
                if (exp_a.size() == 0) begin
                    check_val("a_unexpected_sample", exp_a.size(), 1);
                end else begin
                    check_val("a_sample", {a_dac_q, a_dac_i}, exp_a.pop_front());
                end
                played_a <= played_a + 1;
            end else begin
                check_val("a_idle_code", {a_dac_q, a_dac_i}, IDLE_CODE);
            end
        end
    end

    // Instance B holds each sample for a whole strobe period; samples are unique by sequence.
    logic        b_prev_valid = 1'b0;
    logic [31:0] b_prev_data  = '0;
    int          b_last_cyc   = 0;
    logic        b_saw_full   = 1'b0;

    always @(negedge clk) begin
        if (!b_rst_n) begin
            b_prev_valid <= 1'b0;
        end else begin
            if (b_dac_valid && (!b_prev_valid || {b_dac_q, b_dac_i} != b_prev_data)) begin
                if (exp_b.size() == 0) begin
                    check_val("b_unexpected_sample", exp_b.size(), 1);
                end else begin
                    check_val("b_sample", {b_dac_q, b_dac_i}, exp_b.pop_front());
                end
                if (b_prev_valid) begin
                    check_val("b_pop_spacing", cyc - b_last_cyc, 4);
                end
                b_last_cyc <= cyc;
                played_b   <= played_b + 1;
            end
            if (b_level == 6'd32) begin
                check_val("b_tready_at_full", b_tready, 0);
                b_saw_full <= 1'b1;
            end
            b_prev_valid <= b_dac_valid;
            b_prev_data  <= {b_dac_q, b_dac_i};
        end
    end

    // Offers one beat and returns at the negedge after it is accepted; tvalid stays high.
    task automatic push_beat(input bit sel_b, input logic [31:0] d);
        int n = 0;
        if (sel_b) begin
            b_tdata  = d;
            b_tvalid = 1'b1;
            while (!b_tready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!b_tready) check_val("b_tready_timeout", b_tready, 1);
            else begin
                exp_b.push_back(d);
                @(negedge clk);
            end
        end else begin
            a_tdata  = d;
            a_tvalid = 1'b1;
            while (!a_tready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!a_tready) check_val("a_tready_timeout", a_tready, 1);
            else begin
                exp_a.push_back(d);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(input bit sel_b, input string tag);
        int n = 0;
        while ((sel_b ? b_active : a_active) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, sel_b ? b_active : a_active, 0);
    endtask

    // Returns once A has played everything queued and dropped dac_valid (HOLD).
    task automatic wait_drain_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((a_dac_valid || exp_a.size() != 0) && n < 500);
        check_val("a_drain", a_dac_valid, 0);
    endtask

    int   base, k_lat, len, stall, exp_cnt, pushed;
    logic exp_flag;

    initial begin
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_tvalid = 1'b0; b_tvalid = 1'b0; a_tdata = '0; b_tdata = '0;
        a_clear = 1'b0; b_clear = 1'b0;
        #1 a_rst_n = 1'b0; b_rst_n = 1'b0;
        #1;
        check_val("a_rst_tready", a_tready, 1);
        check_val("a_rst_dac", {a_dac_q, a_dac_i}, IDLE_CODE);
        check_val("a_rst_valid", a_dac_valid, 0);
        check_val("a_rst_active", a_active, 0);
        check_val("a_rst_level", a_level, 0);
        check_val("a_rst_cnt", a_ucnt, 0);
        check_val("a_rst_flag", a_uflag, 0);
        repeat (3) @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);

        // 20 back-to-back beats; first dac_valid one cycle after the level reaches 8.
        base = played_a;
        fork
            begin
                for (int k = 0; k < 20; k++) push_beat(1'b0, next_data());
                a_tvalid = 1'b0;
            end
            begin
                int n = 0;
                while (a_level < 6'd8 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check_val("a_prime_level", a_level, 8);
                check_val("a_valid_at_prime", a_dac_valid, 0);
                @(negedge clk);
                check_val("a_first_valid_lat", a_dac_valid, 1);
            end
        join
        wait_idle(1'b0, "a_idle_after_20");
        check_val("a_played_20", played_a - base, 20);
        check_val("a_left_20", exp_a.size(), 0);
        check_val("a_cnt_20", a_ucnt, 0);

        // 3-beat pulse: 16 quiet cycles in PRIME, then one cycle of output latency.
        base = played_a;
        for (int k = 0; k < 3; k++) push_beat(1'b0, next_data());
        a_tvalid = 1'b0;
        k_lat = 0;
        while (!a_dac_valid && k_lat < 100) begin
            @(negedge clk);
            k_lat++;
        end
        check_val("a_short_prime_exit", k_lat, GAP + 1);
        wait_idle(1'b0, "a_idle_after_3");
        check_val("a_played_3", played_a - base, 3);
        check_val("a_cnt_3", a_ucnt, 0);

        // Random pulses separated by stalls after the stream drains: short stalls are underruns.
        exp_cnt = 0; exp_flag = 1'b0; base = played_a; pushed = 0;
        for (int p = 0; p < 7; p++) begin
            len = int'($urandom_range(9, 16));
            if (p == 1) stall = 5;
            else if (p == 2) stall = int'($urandom_range(1, 12));
            else if ($urandom_range(0, 1) == 1) stall = int'($urandom_range(1, 12));
            else stall = 40;
            if (p > 0) begin
                repeat (stall) @(negedge clk);
                if (stall == 40) check_val("a_gap_to_idle", a_active, 0);
            end
            a_clear = (p == 2);
            push_beat(1'b0, next_data());
            a_clear = 1'b0;
            pushed++;
            if (p > 0 && stall < GAP) begin
                exp_cnt++;
                exp_flag = 1'b1;
            end
            if (p == 2) begin
                exp_cnt  = 0;
                exp_flag = 1'b0;
            end
            if (p > 0) begin
                check_val("a_ucnt", a_ucnt, exp_cnt);
                check_val("a_uflag", a_uflag, exp_flag);
            end
            for (int k = 1; k < len; k++) begin
                push_beat(1'b0, next_data());
                pushed++;
            end
            a_tvalid = 1'b0;
            wait_drain_a();
        end
        wait_idle(1'b0, "a_idle_after_random");
        check_val("a_played_random", played_a - base, pushed);
        check_val("a_left_random", exp_a.size(), 0);
        check_val("a_ucnt_final", a_ucnt, exp_cnt);
        check_val("a_uflag_final", a_uflag, exp_flag);

        // RATE_DIV=4: continuous source fills the FIFO; one pop per 4 cycles, nothing lost.
        base = played_b;
        for (int k = 0; k < 48; k++) push_beat(1'b1, next_data());
        b_tvalid = 1'b0;
        wait_idle(1'b1, "b_idle_after_48");
        check_val("b_saw_full", b_saw_full, 1);
        check_val("b_played_48", played_b - base, 48);
        check_val("b_left_48", exp_b.size(), 0);
        check_val("b_cnt_48", b_ucnt, 0);

        // Asynchronous reset while streaming with 12 entries buffered.
        for (int k = 0; k < 40; k++) begin
            push_beat(1'b1, next_data());
            if (b_level >= 6'd12) break;
        end
        b_tvalid = 1'b0;
        check_val("b_level_pre_rst", b_level, 12);
        check_val("b_active_pre_rst", b_active, 1);
        #2 b_rst_n = 1'b0;
        #1;
        check_val("b_rst_tready", b_tready, 1);
        check_val("b_rst_dac", {b_dac_q, b_dac_i}, IDLE_CODE);
        check_val("b_rst_valid", b_dac_valid, 0);
        check_val("b_rst_active", b_active, 0);
        check_val("b_rst_level", b_level, 0);
        check_val("b_rst_cnt", b_ucnt, 0);
        check_val("b_rst_flag", b_uflag, 0);
        exp_b.delete();
        repeat (2) @(negedge clk);
        b_rst_n = 1'b1;
        @(negedge clk);
        base = played_b;
        for (int k = 0; k < 10; k++) push_beat(1'b1, next_data());
        b_tvalid = 1'b0;
        wait_idle(1'b1, "b_idle_post_rst");
        check_val("b_played_post_rst", played_b - base, 10);
        check_val("b_left_post_rst", exp_b.size(), 0);
        check_val("b_cnt_post_rst", b_ucnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule
